// File: rtl/word_serializer_pkg.sv
// serial_pkg: shared types and constants for the word serializer.
//   ser_state_t   two-state FSM encoding (IDLE, SHIFT)
//   SER_IDLE_BIT  default line level when no payload is being shifted
package serial_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  localparam logic SER_IDLE_BIT = 1'b0;

endpackage

// File: rtl/word_serializer_bit_counter.sv
// bit_counter: position counter for the bit currently on the serial line.
// Ports:
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-high reset
//   clr     in   force the count to zero (has priority over inc)
//   inc     in   advance by one
//   cnt     out  current count, CW bits
//   at_max  out  cnt == MAX
module bit_counter #(
  parameter int MAX = 7,
  localparam int CW = (MAX < 1) ? 1 : $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          at_max
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX);

  assign at_max = (cnt == MAX_C);

  // Returning to zero at MAX is explicit, so the count never depends on
  // natural overflow even when MAX+1 is not a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= at_max ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/word_serializer.sv
// word_serializer: parallel-to-serial front end for the serial sequence
// detector. Accepts WIDTH-bit words over valid/ready and shifts them out one
// bit per enabled clock on ser_out.
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   in_data      in   parallel word (sampled only on accept)
//   in_valid     in   in_data is valid
//   in_ready     out  a word can be accepted this cycle
//   ser_en       in   1 = advance one bit this cycle, 0 = stall
//   ser_out      out  serial bit (IDLE_BIT when nothing is shifting)
//   ser_valid    out  ser_out carries a payload bit this cycle
//   frame_first  out  ser_out is the first bit of a frame
//   frame_last   out  ser_out is the final bit of a frame
module word_serializer
  import serial_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = SER_IDLE_BIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             ser_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_first,
  output logic             frame_last
);

  localparam int CW = $clog2(WIDTH);

  ser_state_t       state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_shifted;
  logic [CW-1:0]    cnt;
  logic             at_max;
  logic             advance;
  logic             last_bit;
  logic             accept;

  // The bit presented on the line is always the head of the shift register.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  assign shreg_shifted = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                                   : {1'b0, shreg[WIDTH-1:1]};

  assign advance  = (state == SHIFT) && ser_en;
  assign last_bit = advance && at_max;

  // Ready in the last-bit cycle lets a new word follow with no gap bit;
  // deliberately independent of in_valid.
  assign in_ready = (state == IDLE) || last_bit;
  assign accept   = in_valid && in_ready;

  // Payload qualification follows the live enable: a stalled cycle still
  // shows the held bit but marks it as not valid.
  assign ser_valid   = advance;
  assign frame_first = advance && (cnt == '0);
  assign frame_last  = last_bit;

  bit_counter #(
    .MAX (WIDTH - 1)
  ) u_bit_counter (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept),
    .inc    (advance),
    .cnt    (cnt),
    .at_max (at_max)
  );

  // ser_out is registered alongside the shift register so it always equals
  // the head bit while shifting and IDLE_BIT otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      ser_out <= IDLE_BIT;
    end else if (accept) begin
      state   <= SHIFT;
      shreg   <= in_data;
      ser_out <= head_bit(in_data);
    end else if (last_bit) begin
      state   <= IDLE;
      shreg   <= shreg_shifted;
      ser_out <= IDLE_BIT;
    end else if (advance) begin
      shreg   <= shreg_shifted;
      ser_out <= head_bit(shreg_shifted);
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// tb_word_serializer: self-checking bench for word_serializer.
// Two instances share one stimulus stream: MSB-first (index 0) and
// LSB-first (index 1). A word-level model predicts every output each cycle;
// directed scenarios add literal expectations on captured serial streams.
module tb_word_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       ser_en = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic rdy_a, so_a, sv_a, ff_a, fl_a;
  logic rdy_b, so_b, sv_b, ff_b, fl_b;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  logic [15:0] cap [2];
  int cap_len [2];
  int vfirst [2];
  int vlast [2];
  int first_cyc [2];
  int last_cyc [2];
  int first_cnt [2];
  int last_cnt [2];

  int         pos [2];
  logic [7:0] word [2];

  always #5 clk = ~clk;

  word_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_msb (
    .clk (clk), .rst (rst), .in_data (in_data), .in_valid (in_valid),
    .in_ready (rdy_a), .ser_en (ser_en), .ser_out (so_a), .ser_valid (sv_a),
    .frame_first (ff_a), .frame_last (fl_a)
  );

  word_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
    .clk (clk), .rst (rst), .in_data (in_data), .in_valid (in_valid),
    .in_ready (rdy_b), .ser_en (ser_en), .ser_out (so_b), .ser_valid (sv_b),
    .frame_first (ff_b), .frame_last (fl_b)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, actual, expected);
  endtask

  // One call = one clock cycle of input values, driven just after the edge.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic en);
    @(posedge clk);
    #1;
    in_valid = v;
    in_data  = d;
    ser_en   = en;
  endtask

  task automatic clearCapture();
    for (int d = 0; d < 2; d++) begin
      cap[d] = '0; cap_len[d] = 0; vfirst[d] = -1; vlast[d] = -1;
      first_cyc[d] = -1; last_cyc[d] = -1; first_cnt[d] = 0; last_cnt[d] = 0;
    end
  endtask

  initial begin
    pos[0] = -1; pos[1] = -1; word[0] = '0; word[1] = '0;
    clearCapture();
  end

  // Model: a word plus the index of the bit on the line (-1 = idle).
  always @(negedge clk) begin
    logic busy, e_val, e_out, e_rdy, e_ff, e_fl;
    logic a_out, a_val, a_rdy, a_ff, a_fl;
    for (int d = 0; d < 2; d++) begin
      if (rst) pos[d] = -1;
      busy  = (pos[d] >= 0);
      e_val = busy && ser_en;
      e_out = busy ? ((d == 0) ? word[d][7 - pos[d]] : word[d][pos[d]]) : 1'b0;
      e_rdy = !busy || (pos[d] == 7 && ser_en);
      e_ff  = e_val && (pos[d] == 0);
      e_fl  = e_val && (pos[d] == 7);
      if (d == 0) begin
        a_out = so_a; a_val = sv_a; a_rdy = rdy_a; a_ff = ff_a; a_fl = fl_a;
      end else begin
        a_out = so_b; a_val = sv_b; a_rdy = rdy_b; a_ff = ff_b; a_fl = fl_b;
      end
      checkOutput($sformatf("cyc%0d dut%0d ser_out", cyc, d), 32'(a_out), 32'(e_out));
      checkOutput($sformatf("cyc%0d dut%0d ser_valid", cyc, d), 32'(a_val), 32'(e_val));
      checkOutput($sformatf("cyc%0d dut%0d in_ready", cyc, d), 32'(a_rdy), 32'(e_rdy));
      checkOutput($sformatf("cyc%0d dut%0d frame_first", cyc, d), 32'(a_ff), 32'(e_ff));
      checkOutput($sformatf("cyc%0d dut%0d frame_last", cyc, d), 32'(a_fl), 32'(e_fl));
      if (a_val) begin
        cap[d] = {cap[d][14:0], a_out};
        if (cap_len[d] == 0) vfirst[d] = cyc;
        vlast[d] = cyc;
        cap_len[d]++;
      end
      if (a_ff) begin first_cnt[d]++; first_cyc[d] = cyc; end
      if (a_fl) begin last_cnt[d]++; last_cyc[d] = cyc; end
      if (!rst) begin
        if (in_valid && e_rdy) begin
          word[d] = in_data;
          pos[d]  = 0;
        end else if (e_val) begin
          pos[d] = (pos[d] == 7) ? -1 : pos[d] + 1;
        end
      end
    end
    cyc++;
  end

  initial begin
    // Reset held for three cycles
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("reset ser_valid", 32'(sv_a), 32'd0);
    checkOutput("reset ser_out", 32'(so_a), 32'd0);
    checkOutput("reset in_ready", 32'(rdy_a), 32'd1);

    // Single word 8'h15
    clearCapture();
    applyStimulus(1'b1, 8'h15, 1'b1);
    repeat (8) applyStimulus(1'b0, 8'h00, 1'b1);
    repeat (2) applyStimulus(1'b0, 8'h00, 1'b0);
    @(negedge clk); #1;
    checkOutput("single msb stream", 32'(cap[0][7:0]), 32'h15);
    checkOutput("single msb length", 32'(cap_len[0]), 32'd8);
    checkOutput("single lsb stream", 32'(cap[1][7:0]), 32'hA8);
    checkOutput("single frame_first count", 32'(first_cnt[0]), 32'd1);
    checkOutput("single frame_last count", 32'(last_cnt[0]), 32'd1);
    checkOutput("single first-to-last", 32'(last_cyc[0] - first_cyc[0]), 32'd7);

    // Back-to-back 8'hA5 then 8'h3C with in_valid held
    clearCapture();
    applyStimulus(1'b1, 8'hA5, 1'b1);
    repeat (8) applyStimulus(1'b1, 8'h3C, 1'b1);
    repeat (8) applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    @(negedge clk); #1;
    checkOutput("b2b msb stream", 32'(cap[0]), 32'hA53C);
    checkOutput("b2b length", 32'(cap_len[0]), 32'd16);
    checkOutput("b2b contiguous span", 32'(vlast[0] - vfirst[0]), 32'd15);
    checkOutput("b2b frame_last count", 32'(last_cnt[0]), 32'd2);
    checkOutput("b2b lsb stream", 32'(cap[1]), 32'hA53C);

    // Stall: bit 4 of 8'hF0 held for 3 cycles
    clearCapture();
    applyStimulus(1'b1, 8'hF0, 1'b1);
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    #1;
    checkOutput("stall ser_out held", 32'(so_a), 32'd1);
    checkOutput("stall ser_valid", 32'(sv_a), 32'd0);
    repeat (2) applyStimulus(1'b0, 8'h00, 1'b0);
    repeat (5) applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    @(negedge clk); #1;
    checkOutput("stall msb stream", 32'(cap[0][7:0]), 32'hF0);
    checkOutput("stall lsb stream", 32'(cap[1][7:0]), 32'h0F);
    checkOutput("stall length", 32'(cap_len[0]), 32'd8);
    checkOutput("stall first-to-last", 32'(last_cyc[0] - first_cyc[0]), 32'd10);

    // Reset mid-frame after bit 3 of 8'hFF
    clearCapture();
    applyStimulus(1'b1, 8'hFF, 1'b1);
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b1);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    checkOutput("midreset ser_valid", 32'(sv_a), 32'd0);
    checkOutput("midreset ser_out", 32'(so_a), 32'd0);
    checkOutput("midreset in_ready", 32'(rdy_a), 32'd1);
    checkOutput("midreset bits before reset", 32'(cap_len[0]), 32'd3);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clearCapture();
    applyStimulus(1'b1, 8'h96, 1'b1);
    repeat (8) applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    @(negedge clk); #1;
    checkOutput("after reset msb stream", 32'(cap[0][7:0]), 32'h96);
    checkOutput("after reset lsb stream", 32'(cap[1][7:0]), 32'h69);
    checkOutput("after reset length", 32'(cap_len[0]), 32'd8);

    // LSB-first 8'h01
    clearCapture();
    applyStimulus(1'b1, 8'h01, 1'b1);
    repeat (8) applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    @(negedge clk); #1;
    checkOutput("lsb-first stream", 32'(cap[1][7:0]), 32'h80);
    checkOutput("lsb-first length", 32'(cap_len[1]), 32'd8);
    checkOutput("msb-first stream 01", 32'(cap[0][7:0]), 32'h01);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
